// File: rtl/hazard_pkg.sv
// hazard_pkg -- shared definitions for the pipeline hazard unit.
//
// Contents:
//   state_t               FSM encodings (IDLE, LSTALL, FLUSH)
//   FWD_RF/FWD_ALU/FWD_LOAD  operand-select codes driven on fwd_a / fwd_b
//   OPC_*                 RV32I major opcodes used for writer / source
//                         qualification (same values as the core's opcode
//                         header)
//   opc_writes_rd()       opcode produces a register result
//   opc_uses_rs1/rs2()    opcode actually reads the given source field
package hazard_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LSTALL = 2'd1,
      FLUSH  = 2'd2
   } state_t;

   localparam logic [1:0] FWD_RF   = 2'd0;
   localparam logic [1:0] FWD_ALU  = 2'd1;
   localparam logic [1:0] FWD_LOAD = 2'd2;

   localparam logic [6:0] OPC_LUI       = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
   localparam logic [6:0] OPC_JAL       = 7'b1101111;
   localparam logic [6:0] OPC_JALR      = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
   localparam logic [6:0] OPC_LOAD      = 7'b0000011;
   localparam logic [6:0] OPC_STORE     = 7'b0100011;
   localparam logic [6:0] OPC_ARI_ITYPE = 7'b0010011;
   localparam logic [6:0] OPC_ARI_RTYPE = 7'b0110011;

   function automatic logic opc_writes_rd(input logic [6:0] opc);
      case (opc)
         OPC_ARI_RTYPE, OPC_ARI_ITYPE, OPC_LUI, OPC_AUIPC,
         OPC_JAL, OPC_JALR, OPC_LOAD: return 1'b1;
         default:                     return 1'b0;
      endcase
   endfunction

   // rs1 field is an immediate / unused for U-type and JAL.
   function automatic logic opc_uses_rs1(input logic [6:0] opc);
      case (opc)
         OPC_LUI, OPC_AUIPC, OPC_JAL: return 1'b0;
         default:                     return 1'b1;
      endcase
   endfunction

   // rs2 field only carries a register for R-type, stores and branches.
   function automatic logic opc_uses_rs2(input logic [6:0] opc);
      case (opc)
         OPC_ARI_RTYPE, OPC_STORE, OPC_BRANCH: return 1'b1;
         default:                              return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/hazard_match.sv
// hazard_match -- compares one execute-stage source operand against the
// write-stage destination.  One instance per source operand.
//
// Ports:
//   w_valid, opc_w, rd_w   write-stage instruction
//   opc_x                  execute-stage opcode (decides whether src is read)
//   src                    execute-stage source index for this operand
//   hit                    write stage produces the register this operand reads
//   hit_load               hit, and the producer is a load
//
// x0 is never a writer, so it can neither forward nor stall.
module hazard_match #(
   parameter int REG_AW = 5,
   parameter bit IS_RS2 = 1'b0
) (
   input  logic              w_valid,
   input  logic [6:0]        opc_w,
   input  logic [REG_AW-1:0] rd_w,
   input  logic [6:0]        opc_x,
   input  logic [REG_AW-1:0] src,
   output logic              hit,
   output logic              hit_load
);
   import hazard_pkg::*;

   logic writer;
   logic used;

   always_comb begin
      writer   = w_valid && (rd_w != '0) && opc_writes_rd(opc_w);
      used     = IS_RS2 ? opc_uses_rs2(opc_x) : opc_uses_rs1(opc_x);
      hit      = writer && used && (src == rd_w);
      hit_load = hit && (opc_w == OPC_LOAD);
   end

endmodule

// File: rtl/hazard_unit.sv
// hazard_unit -- forwarding, load-use stall and branch-flush control for a
// short in-order pipeline (execute stage X, write stage W).
//
// Parameters:
//   REG_AW       register-index width
//   LOAD_LAT     stalled cycles per load-use hazard (1..7)
//   FLUSH_DEPTH  bubble cycles after a taken branch / jump (1..7)
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   x_valid, opc_x, rs1_x, rs2_x   execute-stage instruction
//   w_valid, opc_w, rd_w           write-stage instruction
//   redirect                   branch taken or JAL/JALR resolved in execute
//   fwd_a, fwd_b               operand select (FWD_RF / FWD_ALU / FWD_LOAD)
//   stall_pc, hold_x, bubble   load-use stall controls
//   flush                      kill fetch/decode
//   stall_count, flush_count   (only with HAZARD_PERF_EN) saturating 16-bit
//                              counts of stalled / flushed cycles
//
// Optional feature macro: HAZARD_PERF_EN.
//
// Timing: the hazard is detected combinationally in IDLE and the first
// stalled/flushed cycle is that same cycle.  cnt is loaded with the number of
// remaining cycles after it, so LSTALL/FLUSH last LOAD_LAT-1 / FLUSH_DEPTH-1
// cycles and a depth of 1 never leaves IDLE.  cnt reaches 0 as the FSM
// returns to IDLE.  Outputs are forced to 0 while rst_n is low.
module hazard_unit #(
   parameter int REG_AW      = 5,
   parameter int LOAD_LAT    = 1,
   parameter int FLUSH_DEPTH = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              x_valid,
   input  logic [6:0]        opc_x,
   input  logic [REG_AW-1:0] rs1_x,
   input  logic [REG_AW-1:0] rs2_x,
   input  logic              w_valid,
   input  logic [6:0]        opc_w,
   input  logic [REG_AW-1:0] rd_w,
   input  logic              redirect,
   output logic [1:0]        fwd_a,
   output logic [1:0]        fwd_b,
   output logic              stall_pc,
   output logic              hold_x,
   output logic              bubble,
   output logic              flush
`ifdef HAZARD_PERF_EN
   ,
   output logic [15:0]       stall_count,
   output logic [15:0]       flush_count
`endif
);
   import hazard_pkg::*;

   localparam logic [2:0] LL_INIT = 3'(LOAD_LAT - 1);
   localparam logic [2:0] FD_INIT = 3'(FLUSH_DEPTH - 1);

   logic       hit_a, hit_b, ld_a, ld_b;
   logic       load_haz, take_redirect;

   state_t     state, state_n;
   logic [2:0] cnt, cnt_n;
   // Which operands matched the load; the load has left W by the final
   // stall cycle, so the match must be remembered.
   logic       lm_a, lm_b, lm_a_n, lm_b_n;

   logic [1:0] fwd_a_c, fwd_b_c;
   logic       stall_c, flush_c;

   hazard_match #(.REG_AW(REG_AW), .IS_RS2(1'b0)) u_match_a (
      .w_valid  (w_valid),
      .opc_w    (opc_w),
      .rd_w     (rd_w),
      .opc_x    (opc_x),
      .src      (rs1_x),
      .hit      (hit_a),
      .hit_load (ld_a)
   );

   hazard_match #(.REG_AW(REG_AW), .IS_RS2(1'b1)) u_match_b (
      .w_valid  (w_valid),
      .opc_w    (opc_w),
      .rd_w     (rd_w),
      .opc_x    (opc_x),
      .src      (rs2_x),
      .hit      (hit_b),
      .hit_load (ld_b)
   );

   // A load hazard wins over a simultaneous redirect; the held branch
   // re-presents redirect once the stall releases.
   assign load_haz      = x_valid && (ld_a || ld_b);
   assign take_redirect = x_valid && redirect && !load_haz;

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      lm_a_n  = lm_a;
      lm_b_n  = lm_b;
      fwd_a_c = FWD_RF;
      fwd_b_c = FWD_RF;
      stall_c = 1'b0;
      flush_c = 1'b0;
      case (state)
         IDLE: begin
            if (load_haz) begin
               stall_c = 1'b1;
               lm_a_n  = ld_a;
               lm_b_n  = ld_b;
               if (LOAD_LAT == 1) begin
                  // Only stall cycle is also the last one: load data ready.
                  fwd_a_c = ld_a ? FWD_LOAD : FWD_RF;
                  fwd_b_c = ld_b ? FWD_LOAD : FWD_RF;
               end else begin
                  state_n = LSTALL;
                  cnt_n   = LL_INIT;
               end
            end else begin
               fwd_a_c = (x_valid && hit_a) ? FWD_ALU : FWD_RF;
               fwd_b_c = (x_valid && hit_b) ? FWD_ALU : FWD_RF;
               if (take_redirect) begin
                  flush_c = 1'b1;
                  if (FLUSH_DEPTH != 1) begin
                     state_n = FLUSH;
                     cnt_n   = FD_INIT;
                  end
               end
            end
         end
         LSTALL: begin
            stall_c = 1'b1;
            if (cnt <= 3'd1) begin
               fwd_a_c = lm_a ? FWD_LOAD : FWD_RF;
               fwd_b_c = lm_b ? FWD_LOAD : FWD_RF;
               state_n = IDLE;
               cnt_n   = 3'd0;
            end else begin
               cnt_n = cnt - 3'd1;
            end
         end
         FLUSH: begin
            flush_c = 1'b1;
            if (cnt <= 3'd1) begin
               state_n = IDLE;
               cnt_n   = 3'd0;
            end else begin
               cnt_n = cnt - 3'd1;
            end
         end
         default: begin
            state_n = IDLE;
            cnt_n   = 3'd0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= 3'd0;
         lm_a  <= 1'b0;
         lm_b  <= 1'b0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         lm_a  <= lm_a_n;
         lm_b  <= lm_b_n;
      end
   end

   assign fwd_a    = rst_n ? fwd_a_c : FWD_RF;
   assign fwd_b    = rst_n ? fwd_b_c : FWD_RF;
   assign stall_pc = rst_n && stall_c;
   assign hold_x   = rst_n && stall_c;
   assign bubble   = rst_n && (stall_c || flush_c);
   assign flush    = rst_n && flush_c;

`ifdef HAZARD_PERF_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_count <= 16'd0;
         flush_count <= 16'd0;
      end else begin
         if (stall_c && (stall_count != 16'hFFFF))
            stall_count <= stall_count + 16'd1;
         if (flush_c && (flush_count != 16'hFFFF))
            flush_count <= flush_count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: two instances driven from the same inputs,
// u_dut3 (LOAD_LAT=3, FLUSH_DEPTH=2) and u_dut1 (LOAD_LAT=1, FLUSH_DEPTH=1).
// Each stimulus cycle pushes the hand-derived outputs of both instances into
// exp_q; a negedge monitor pops and compares.
module tb_hazard_unit;

   localparam logic [6:0] RT = 7'h33;  // R-type ALU
   localparam logic [6:0] IT = 7'h13;  // I-type ALU
   localparam logic [6:0] LD = 7'h03;
   localparam logic [6:0] SW = 7'h23;
   localparam logic [6:0] BR = 7'h63;
   localparam logic [6:0] LU = 7'h37;
   localparam logic [6:0] JL = 7'h6F;

   logic       clk;
   logic       rst_n;
   logic       x_valid;
   logic [6:0] opc_x;
   logic [4:0] rs1_x, rs2_x;
   logic       w_valid;
   logic [6:0] opc_w;
   logic [4:0] rd_w;
   logic       redirect;

   logic [1:0] fwd_a3, fwd_b3, fwd_a1, fwd_b1;
   logic       stall3, hold3, bubble3, flush3;
   logic       stall1, hold1, bubble1, flush1;
`ifdef HAZARD_PERF_EN
   logic [15:0] scnt3, fcnt3, scnt1, fcnt1;
`endif

   logic [15:0] exp_q[$];
   string       name_q[$];
   logic        obs_v;
   int          n_checks;
   int          n_pass;
   logic [15:0] mon_exp, mon_act;
   string       mon_nm;

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   hazard_unit #(.REG_AW(5), .LOAD_LAT(3), .FLUSH_DEPTH(2)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .x_valid(x_valid), .opc_x(opc_x),
      .rs1_x(rs1_x), .rs2_x(rs2_x), .w_valid(w_valid), .opc_w(opc_w),
      .rd_w(rd_w), .redirect(redirect), .fwd_a(fwd_a3), .fwd_b(fwd_b3),
      .stall_pc(stall3), .hold_x(hold3), .bubble(bubble3), .flush(flush3)
`ifdef HAZARD_PERF_EN
      , .stall_count(scnt3), .flush_count(fcnt3)
`endif
   );

   hazard_unit #(.REG_AW(5), .LOAD_LAT(1), .FLUSH_DEPTH(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .x_valid(x_valid), .opc_x(opc_x),
      .rs1_x(rs1_x), .rs2_x(rs2_x), .w_valid(w_valid), .opc_w(opc_w),
      .rd_w(rd_w), .redirect(redirect), .fwd_a(fwd_a1), .fwd_b(fwd_b1),
      .stall_pc(stall1), .hold_x(hold1), .bubble(bubble1), .flush(flush1)
`ifdef HAZARD_PERF_EN
      , .stall_count(scnt1), .flush_count(fcnt1)
`endif
   );

   // Expected-output packing: {fwd_a, fwd_b, stall_pc, hold_x, bubble, flush}.
   function automatic logic [7:0] ev(input logic [1:0] fa, input logic [1:0] fb,
                                     input logic st, input logic fl);
      return {fa, fb, st, st, (st | fl), fl};
   endfunction

   // ---------------- driver ----------------
   task automatic step(input string nm, input logic rn, input logic xv,
                       input logic [6:0] ox, input logic [4:0] r1, input logic [4:0] r2,
                       input logic wv, input logic [6:0] ow, input logic [4:0] rd,
                       input logic rdr, input logic [7:0] e3, input logic [7:0] e1);
      @(posedge clk);
      #1;
      rst_n    = rn;
      x_valid  = xv;
      opc_x    = ox;
      rs1_x    = r1;
      rs2_x    = r2;
      w_valid  = wv;
      opc_w    = ow;
      rd_w     = rd;
      redirect = rdr;
      exp_q.push_back({e3, e1});
      name_q.push_back(nm);
      obs_v = 1'b1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      if (obs_v) begin
         mon_act = {fwd_a3, fwd_b3, stall3, hold3, bubble3, flush3,
                    fwd_a1, fwd_b1, stall1, hold1, bubble1, flush1};
         n_checks++;
         if (exp_q.size() == 0) begin
            $display("FAIL scoreboard_underflow: got output %h with no expected entry", mon_act);
         end else begin
            mon_exp = exp_q.pop_front();
            mon_nm  = name_q.pop_front();
            if (mon_act === mon_exp) n_pass++;
            else $display("FAIL %s: got %h expected %h (dut3 | dut1)", mon_nm, mon_act, mon_exp);
         end
      end
   end

   // ---------------- watchdog ----------------
   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $display("%0d/%0d checks passed", n_pass, n_checks + 1);
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   localparam logic [7:0] Z = 8'h00;

   initial begin
      n_checks = 0;
      n_pass   = 0;
      obs_v    = 1'b0;
      rst_n    = 1'b0;
      x_valid  = 1'b0;
      opc_x    = IT;
      rs1_x    = '0;
      rs2_x    = '0;
      w_valid  = 1'b0;
      opc_w    = IT;
      rd_w     = '0;
      redirect = 1'b0;

      // reset forces outputs low even with a forwarding pattern applied
      step("reset_out",   0, 1, RT, 5, 6, 1, RT, 5, 0, Z, Z);
      step("idle_xv0",    1, 0, RT, 5, 6, 1, RT, 5, 0, Z, Z);
      step("alu_fwd_a",   1, 1, RT, 5, 6, 1, RT, 5, 0, ev(1,0,0,0), ev(1,0,0,0));
      step("alu_fwd_b",   1, 1, SW, 1, 5, 1, IT, 5, 0, ev(0,1,0,0), ev(0,1,0,0));
      step("fwd_both",    1, 1, RT, 5, 5, 1, LU, 5, 0, ev(1,1,0,0), ev(1,1,0,0));
      step("rs2_unused",  1, 1, IT, 1, 5, 1, RT, 5, 0, Z, Z);
      step("rs1_unused",  1, 1, LU, 5, 0, 1, RT, 5, 0, Z, Z);
      step("jal_writer",  1, 1, BR, 9, 2, 1, JL, 9, 0, ev(1,0,0,0), ev(1,0,0,0));
      step("x0_alu",      1, 1, RT, 0, 0, 1, RT, 0, 0, Z, Z);
      step("x0_load",     1, 1, RT, 0, 0, 1, LD, 0, 0, Z, Z);
      step("non_writer",  1, 1, RT, 5, 6, 1, SW, 5, 0, Z, Z);
      step("w_invalid",   1, 1, RT, 5, 6, 0, RT, 5, 0, Z, Z);

      // LW x7 then reader of rs2=x7: 3 stalled cycles on dut3, 1 on dut1
      step("lu_c1",       1, 1, RT, 1, 7, 1, LD, 7, 0, ev(0,0,1,0), ev(0,2,1,0));
      step("lu_c2",       1, 1, RT, 1, 7, 0, IT, 0, 0, ev(0,0,1,0), Z);
      step("lu_c3",       1, 1, RT, 1, 7, 0, IT, 0, 0, ev(0,2,1,0), Z);
      step("lu_done",     1, 1, RT, 1, 7, 0, IT, 0, 0, Z, Z);

      // load hazard with redirect: stall first, flush when the branch is released
      step("ldbr_c1",     1, 1, BR, 7, 2, 1, LD, 7, 1, ev(0,0,1,0), ev(2,0,1,0));
      step("ldbr_c2",     1, 1, BR, 7, 2, 0, IT, 0, 1, ev(0,0,1,0), ev(0,0,0,1));
      step("ldbr_c3",     1, 1, BR, 7, 2, 0, IT, 0, 1, ev(2,0,1,0), ev(0,0,0,1));
      step("ldbr_redir",  1, 1, BR, 7, 2, 0, IT, 0, 1, ev(0,0,0,1), ev(0,0,0,1));
      step("ldbr_flush2", 1, 0, RT, 0, 0, 0, IT, 0, 0, ev(0,0,0,1), Z);

      // plain BEQ redirect; hazards presented during FLUSH are ignored
      step("br_c1",       1, 1, BR, 1, 2, 0, IT, 0, 1, ev(0,0,0,1), ev(0,0,0,1));
      step("br_c2",       1, 1, RT, 5, 6, 1, LD, 5, 1, ev(0,0,0,1), ev(2,0,1,0));
      step("br_idle",     1, 1, RT, 5, 6, 1, RT, 5, 0, ev(1,0,0,0), ev(1,0,0,0));

      // reset during cycle 2 of a 3-cycle load stall
      step("rl_c1",       1, 1, RT, 1, 7, 1, LD, 7, 0, ev(0,0,1,0), ev(0,2,1,0));
      step("rl_rst",      0, 1, RT, 1, 7, 1, LD, 7, 0, Z, Z);
      step("rl_after",    1, 1, RT, 1, 7, 0, IT, 0, 0, Z, Z);

      // reset during a flush sequence
      step("rf_c1",       1, 1, BR, 1, 2, 0, IT, 0, 1, ev(0,0,0,1), ev(0,0,0,1));
      step("rf_rst",      0, 1, BR, 1, 2, 0, IT, 0, 1, Z, Z);
      step("rf_after",    1, 0, RT, 0, 0, 0, IT, 0, 0, Z, Z);

      @(posedge clk);
      #1;
      obs_v = 1'b0;
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

`ifdef HAZARD_PERF_EN
      rst_n = 1'b0;
      #2;
      chk("perf_rst_stall3", {16'd0, scnt3}, 32'd0);
      chk("perf_rst_flush1", {16'd0, fcnt1}, 32'd0);
      rst_n    = 1'b1;
      x_valid  = 1'b1;
      opc_x    = RT;
      rs1_x    = 5'd1;
      rs2_x    = 5'd7;
      w_valid  = 1'b1;
      opc_w    = LD;
      rd_w     = 5'd7;
      redirect = 1'b0;
      // every cycle is a stall cycle on both instances with this pattern held
      repeat (70000) @(posedge clk);
      #1;
      chk("perf_sat_stall3", {16'd0, scnt3}, 32'h0000FFFF);
      chk("perf_sat_stall1", {16'd0, scnt1}, 32'h0000FFFF);
      chk("perf_flush3",     {16'd0, fcnt3}, 32'd0);
      x_valid = 1'b0;
      w_valid = 1'b0;
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
